// File: rtl/armaria_isa_pkg.sv
// ARMAria ISA constants shared by the instruction encoder and its word packer:
// field widths, opcode nibbles, instruction IDs and fixed instruction words.
package armaria_isa_pkg;

    localparam int INSTRUCTION_WIDTH      = 16;
    localparam int ID_WIDTH               = 7;
    localparam int REGISTER_WIDTH         = 4;
    localparam int OFFSET_WIDTH           = 12;
    localparam int BRANCH_CONDITION_WIDTH = 5;

    localparam logic [3:0] OP_0 = 4'h0;
    localparam logic [3:0] OP_1 = 4'h1;
    localparam logic [3:0] OP_2 = 4'h2;
    localparam logic [3:0] OP_3 = 4'h3;
    localparam logic [3:0] OP_4 = 4'h4;
    localparam logic [3:0] OP_5 = 4'h5;
    localparam logic [3:0] OP_6 = 4'h6;
    localparam logic [3:0] OP_7 = 4'h7;
    localparam logic [3:0] OP_8 = 4'h8;
    localparam logic [3:0] OP_9 = 4'h9;
    localparam logic [3:0] OP_A = 4'ha;
    localparam logic [3:0] OP_B = 4'hb;
    localparam logic [3:0] OP_C = 4'hc;
    localparam logic [3:0] OP_D = 4'hd;
    localparam logic [3:0] OP_E = 4'he;
    localparam logic [3:0] OP_F = 4'hf;

    localparam logic [ID_WIDTH-1:0] ID_LSL          = 7'd1;
    localparam logic [ID_WIDTH-1:0] ID_LSR          = 7'd2;
    localparam logic [ID_WIDTH-1:0] ID_ASR          = 7'd3;
    localparam logic [ID_WIDTH-1:0] ID_ADD3_FIRST   = 7'd4;
    localparam logic [ID_WIDTH-1:0] ID_ADD3_LAST    = 7'd7;
    localparam logic [ID_WIDTH-1:0] ID_IMM8_FIRST   = 7'd8;
    localparam logic [ID_WIDTH-1:0] ID_IMM8_LAST    = 7'd11;
    localparam logic [ID_WIDTH-1:0] ID_ALU_FIRST    = 7'd12;
    localparam logic [ID_WIDTH-1:0] ID_ALU_LAST     = 7'd27;
    localparam logic [ID_WIDTH-1:0] ID_GRP4_FIRST   = 7'd28;
    localparam logic [ID_WIDTH-1:0] ID_GRP4_LAST    = 7'd30;
    localparam logic [ID_WIDTH-1:0] ID_GRP5_FIRST   = 7'd31;
    localparam logic [ID_WIDTH-1:0] ID_GRP5_LAST    = 7'd33;
    localparam logic [ID_WIDTH-1:0] ID_GRP6_FIRST   = 7'd34;
    localparam logic [ID_WIDTH-1:0] ID_GRP6_LAST    = 7'd37;
    localparam logic [ID_WIDTH-1:0] ID_COND_REG     = 7'd38;
    localparam logic [ID_WIDTH-1:0] ID_IMM8_ALT     = 7'd39;
    localparam logic [ID_WIDTH-1:0] ID_HIREG_FIRST  = 7'd40;
    localparam logic [ID_WIDTH-1:0] ID_HIREG_LAST   = 7'd47;
    localparam logic [ID_WIDTH-1:0] ID_MEM_FIRST    = 7'd48;
    localparam logic [ID_WIDTH-1:0] ID_MEM_LAST     = 7'd53;
    localparam logic [ID_WIDTH-1:0] ID_MEM_SP_FIRST = 7'd54;
    localparam logic [ID_WIDTH-1:0] ID_MEM_SP_LAST  = 7'd57;
    localparam logic [ID_WIDTH-1:0] ID_MISC_A       = 7'd58;
    localparam logic [ID_WIDTH-1:0] ID_B2_FIRST     = 7'd59;
    localparam logic [ID_WIDTH-1:0] ID_B2_LAST      = 7'd62;
    localparam logic [ID_WIDTH-1:0] ID_BA_FIRST     = 7'd63;
    localparam logic [ID_WIDTH-1:0] ID_BA_LAST      = 7'd66;
    localparam logic [ID_WIDTH-1:0] ID_B4           = 7'd67;
    localparam logic [ID_WIDTH-1:0] ID_BD           = 7'd68;
    localparam logic [ID_WIDTH-1:0] ID_BE_FIRST     = 7'd69;
    localparam logic [ID_WIDTH-1:0] ID_BE_NOREG     = 7'd70;
    localparam logic [ID_WIDTH-1:0] ID_BE_LAST      = 7'd71;
    localparam logic [ID_WIDTH-1:0] ID_SWI          = 7'd72;
    localparam logic [ID_WIDTH-1:0] ID_BCOND        = 7'd73;
    localparam logic [ID_WIDTH-1:0] ID_NOP          = 7'd74;
    localparam logic [ID_WIDTH-1:0] ID_HLT          = 7'd75;
    localparam logic [ID_WIDTH-1:0] ID_MISC_B       = 7'd76;
    localparam logic [ID_WIDTH-1:0] ID_COND_ALL     = 7'd77;
    localparam logic [ID_WIDTH-1:0] ID_HLT_ALT      = 7'd78;
    localparam logic [ID_WIDTH-1:0] ID_RESET        = 7'd100;

    localparam logic [INSTRUCTION_WIDTH-1:0] SWI_WORD   = 16'hc000;
    localparam logic [INSTRUCTION_WIDTH-1:0] NOP_WORD   = 16'he000;
    localparam logic [INSTRUCTION_WIDTH-1:0] HLT_WORD   = 16'he800;
    localparam logic [INSTRUCTION_WIDTH-1:0] RESET_WORD = 16'hffff;

    typedef struct packed {
        logic [ID_WIDTH-1:0]               id;
        logic [REGISTER_WIDTH-1:0]         reg_d;
        logic [REGISTER_WIDTH-1:0]         reg_a;
        logic [REGISTER_WIDTH-1:0]         reg_b;
        logic [OFFSET_WIDTH-1:0]           offset;
        logic [BRANCH_CONDITION_WIDTH-1:0] cond;
    } fields_t;

endpackage

// File: rtl/instruction_word_packer.sv
// Combinational packer: decoded ARMAria fields -> 16-bit instruction word plus a
// legal flag. Unknown IDs produce word 0 with legal low.
module instruction_word_packer
    import armaria_isa_pkg::*;
(
    input  fields_t                        fields,
    output logic [INSTRUCTION_WIDTH-1:0]   word,
    output logic                           legal
);

    logic [ID_WIDTH-1:0] id;
    logic [2:0]          rd;
    logic [2:0]          ra;
    logic [2:0]          rb;
    logic [4:0]          off5;
    logic [7:0]          off8;
    logic [3:0]          cond;
    logic [ID_WIDTH-1:0] rel;
    logic                unused_bits;

    // Only the low three register bits exist in the 16-bit formats.
    assign id   = fields.id;
    assign rd   = fields.reg_d[2:0];
    assign ra   = fields.reg_a[2:0];
    assign rb   = fields.reg_b[2:0];
    assign off5 = fields.offset[4:0];
    assign off8 = fields.offset[7:0];
    assign cond = fields.cond[3:0];

    assign unused_bits = ^{fields.reg_d[3], fields.reg_a[3], fields.reg_b[3],
                           fields.offset[11:8], fields.cond[4], rel[6:5]};

    always_comb begin
        word  = '0;
        legal = 1'b1;
        rel   = '0;
        case (id) inside
            [ID_LSL:ID_LSR]:                 word = {OP_0, id[1], off5, ra, rd};
            ID_ASR:                          word = {5'b00010, off5, ra, rd};
            [ID_ADD3_FIRST:ID_ADD3_LAST]:    word = {5'b00011, id[1:0], (id[1] ? off5[2:0] : rb), ra, rd};
            [ID_IMM8_FIRST:ID_IMM8_LAST]:    word = {(id[1] ? OP_3 : OP_2), id[0], rd, off8};
            ID_IMM8_ALT:                     word = {5'b01001, rd, off8};
            [ID_ALU_FIRST:ID_ALU_LAST]: begin
                rel  = id - ID_ALU_FIRST;
                word = {5'b01000, rel[4:2], rel[1:0], rb, rd};
            end
            [ID_GRP4_FIRST:ID_GRP4_LAST]: begin
                rel  = id - 7'd27;
                word = {OP_4, 4'h4, rel[1:0], rb, rd};
            end
            [ID_GRP5_FIRST:ID_GRP5_LAST]: begin
                rel  = id - 7'd30;
                word = {OP_4, 4'h5, rel[1:0], rb, rd};
            end
            [ID_GRP6_FIRST:ID_GRP6_LAST]: begin
                rel  = id - ID_GRP6_FIRST;
                word = {OP_4, 4'h6, rel[1:0], rb, rd};
            end
            ID_COND_REG, ID_COND_ALL:        word = {8'h47, ((id == ID_COND_ALL) ? 4'hf : cond), 1'b0, rb};
            [ID_HIREG_FIRST:ID_HIREG_LAST]: begin
                rel  = id - ID_HIREG_FIRST;
                word = {OP_5, rel[2:0], rb, ra, rd};
            end
            [ID_MEM_FIRST:ID_MEM_LAST]: begin
                rel  = id - ID_MEM_FIRST;
                word = {OP_6 + {2'b00, rel[2:1]}, id[0], off5, ra, rd};
            end
            [ID_MEM_SP_FIRST:ID_MEM_SP_LAST]: begin
                rel  = id - ID_MEM_SP_FIRST;
                word = {(rel[1] ? OP_A : OP_9), id[0], rd, off8};
            end
            ID_MISC_A, ID_MISC_B:            word = {OP_B, 4'h0, 1'b0, (id == ID_MISC_B), 3'b000, rd};
            [ID_B2_FIRST:ID_B2_LAST]: begin
                rel  = id - ID_B2_FIRST;
                word = {OP_B, 4'h2, rel[1:0], rb, rd};
            end
            [ID_BA_FIRST:ID_BA_LAST]: begin
                rel  = id - ID_BA_FIRST;
                word = {OP_B, 4'ha, rel[1:0], rb, rd};
            end
            ID_B4:                           word = {OP_B, 4'h4, 5'b00000, rd};
            ID_BD:                           word = {OP_B, 4'hd, 5'b00000, rd};
            [ID_BE_FIRST:ID_BE_LAST]: begin
                rel  = id - ID_BE_FIRST;
                word = {OP_B, 4'he, rel[1:0], 3'b000, ((id == ID_BE_NOREG) ? 3'b000 : rd)};
            end
            ID_SWI:                          word = SWI_WORD;
            ID_BCOND:                        word = {OP_D, cond, off8};
            ID_NOP:                          word = NOP_WORD;
            ID_HLT, ID_HLT_ALT:              word = HLT_WORD;
            ID_RESET:                        word = RESET_WORD;
            default:                         legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Streams packed ARMAria words into instruction memory from a base address.
// Optional running checksum output enabled by defining ENCODER_CHECKSUM_EN.
module instruction_encoder
    import armaria_isa_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
)
(
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ID_WIDTH-1:0]               ID,
    input  logic [REGISTER_WIDTH-1:0]         RegD,
    input  logic [REGISTER_WIDTH-1:0]         RegA,
    input  logic [REGISTER_WIDTH-1:0]         RegB,
    input  logic [OFFSET_WIDTH-1:0]           Offset,
    input  logic [BRANCH_CONDITION_WIDTH-1:0] branch_condition,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0]      mem_data,
    output logic [ADDR_WIDTH:0]               word_count,
    output logic                              full,
`ifdef ENCODER_CHECKSUM_EN
    output logic [INSTRUCTION_WIDTH-1:0]      checksum,
`endif
    output logic                              illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = 1;

    logic [1:0]                   state_reg;
    logic [ADDR_WIDTH-1:0]        ptr_reg;
    logic [ADDR_WIDTH:0]          word_count_reg;
    logic                         mem_we_reg;
    logic [ADDR_WIDTH-1:0]        mem_addr_reg;
    logic [INSTRUCTION_WIDTH-1:0] mem_data_reg;
    logic                         illegal_reg;
    logic [INSTRUCTION_WIDTH-1:0] checksum_reg;

    fields_t                      fields;
    logic [INSTRUCTION_WIDTH-1:0] packed_word;
    logic                         packed_legal;
    logic                         handshake;

    assign fields = '{id: ID, reg_d: RegD, reg_a: RegA, reg_b: RegB,
                      offset: Offset, cond: branch_condition};

    instruction_word_packer u_packer (
        .fields (fields),
        .word   (packed_word),
        .legal  (packed_legal)
    );

    assign in_ready  = (state_reg == S_RUN);
    assign handshake = in_valid && in_ready;

    // start takes priority: a bundle offered alongside it is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            ptr_reg        <= '0;
            word_count_reg <= '0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
            illegal_reg    <= 1'b0;
            checksum_reg   <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            if (start) begin
                state_reg      <= S_RUN;
                ptr_reg        <= base_addr;
                word_count_reg <= '0;
                illegal_reg    <= 1'b0;
                checksum_reg   <= '0;
            end else if (handshake) begin
                if (packed_legal) begin
                    mem_we_reg     <= 1'b1;
                    mem_addr_reg   <= ptr_reg;
                    mem_data_reg   <= packed_word;
                    ptr_reg        <= ptr_reg + ADDR_ONE;
                    word_count_reg <= word_count_reg + COUNT_ONE;
                    checksum_reg   <= checksum_reg + packed_word;
                    if (ptr_reg == LAST_ADDR) begin
                        state_reg <= S_FULL;
                    end
                end else begin
                    illegal_reg <= 1'b1;
                end
            end
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_data   = mem_data_reg;
    assign word_count = word_count_reg;
    assign full       = (state_reg == S_FULL);
    assign illegal    = illegal_reg;

`ifdef ENCODER_CHECKSUM_EN
    assign checksum = checksum_reg;
`else
    logic unused_checksum;
    assign unused_checksum = ^checksum_reg;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed scenarios plus a randomized
// sweep over every legal ID checked against an arithmetic encoding model.
module tb_instruction_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  ID;
    logic [3:0]  RegD;
    logic [3:0]  RegA;
    logic [3:0]  RegB;
    logic [11:0] Offset;
    logic [4:0]  branch_condition;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_data;
    logic [12:0] word_count;
    logic        full;
    logic        illegal;

    logic        s_start;
    logic [3:0]  s_base_addr;
    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_mem_we;
    logic [3:0]  s_mem_addr;
    logic [15:0] s_mem_data;
    logic [4:0]  s_word_count;
    logic        s_full;
    logic        s_illegal;
`ifdef ENCODER_CHECKSUM_EN
    logic [15:0] checksum;
    logic [15:0] s_checksum;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    instruction_encoder #(.ADDR_WIDTH(12)) u_dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .ID(ID), .RegD(RegD), .RegA(RegA),
        .RegB(RegB), .Offset(Offset), .branch_condition(branch_condition),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .word_count(word_count), .full(full),
`ifdef ENCODER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .illegal(illegal)
    );

    instruction_encoder #(.ADDR_WIDTH(4)) u_small (
        .clock(clock), .reset(reset), .start(s_start), .base_addr(s_base_addr),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .ID(ID), .RegD(RegD), .RegA(RegA),
        .RegB(RegB), .Offset(Offset), .branch_condition(branch_condition),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
        .word_count(s_word_count), .full(s_full),
`ifdef ENCODER_CHECKSUM_EN
        .checksum(s_checksum),
`endif
        .illegal(s_illegal)
    );

    // Encoding model built from field positions with plain arithmetic.
    function automatic logic [15:0] ref_word(input int id, input int rd_in, input int ra_in,
                                             input int rb_in, input int off_in, input int cond_in,
                                             output bit legal);
        int d;
        int a;
        int b;
        int o5;
        int o8;
        int c;
        int w;
        d = rd_in % 8;
        a = ra_in % 8;
        b = rb_in % 8;
        o5 = off_in % 32;
        o8 = off_in % 256;
        c = cond_in % 16;
        legal = 1'b1;
        w = 0;
        if (id == 1 || id == 2)        w = (id - 1) * 2048 + o5 * 64 + a * 8 + d;
        else if (id == 3)              w = 2 * 2048 + o5 * 64 + a * 8 + d;
        else if (id >= 4 && id <= 7)   w = 3 * 2048 + (id - 4) * 512 + ((id < 6) ? b : (off_in % 8)) * 64 + a * 8 + d;
        else if (id >= 8 && id <= 11)  w = (2 + (id - 8) / 2) * 4096 + (id % 2) * 2048 + d * 256 + o8;
        else if (id == 39)             w = 9 * 2048 + d * 256 + o8;
        else if (id >= 12 && id <= 27) w = 8 * 2048 + ((id - 12) / 4) * 256 + ((id - 12) % 4) * 64 + b * 8 + d;
        else if (id >= 28 && id <= 30) w = 4 * 4096 + 4 * 256 + (id - 27) * 64 + b * 8 + d;
        else if (id >= 31 && id <= 33) w = 4 * 4096 + 5 * 256 + (id - 30) * 64 + b * 8 + d;
        else if (id >= 34 && id <= 37) w = 4 * 4096 + 6 * 256 + (id - 34) * 64 + b * 8 + d;
        else if (id == 38 || id == 77) w = 'h47 * 256 + ((id == 77) ? 15 : c) * 16 + b;
        else if (id >= 40 && id <= 47) w = 5 * 4096 + (id - 40) * 512 + b * 64 + a * 8 + d;
        else if (id >= 48 && id <= 53) w = (6 + (id - 48) / 2) * 4096 + (id % 2) * 2048 + o5 * 64 + a * 8 + d;
        else if (id >= 54 && id <= 57) w = (9 + (id - 54) / 2) * 4096 + (id % 2) * 2048 + d * 256 + o8;
        else if (id == 58 || id == 76) w = 'hb0 * 256 + ((id == 76) ? 64 : 0) + d;
        else if (id >= 59 && id <= 62) w = 'hb2 * 256 + (id - 59) * 64 + b * 8 + d;
        else if (id >= 63 && id <= 66) w = 'hba * 256 + (id - 63) * 64 + b * 8 + d;
        else if (id == 67)             w = 'hb4 * 256 + d;
        else if (id == 68)             w = 'hbd * 256 + d;
        else if (id >= 69 && id <= 71) w = 'hbe * 256 + (id - 69) * 64 + ((id == 70) ? 0 : d);
        else if (id == 72)             w = 'hc000;
        else if (id == 73)             w = 'hd000 + c * 256 + o8;
        else if (id == 74)             w = 'he000;
        else if (id == 75 || id == 78) w = 'he800;
        else if (id == 100)            w = 'hffff;
        else                           legal = 1'b0;
        return w[15:0];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_fields(input int id, input int rd, input int ra, input int rb,
                              input int off, input int cond);
        ID = id[6:0];
        RegD = rd[3:0];
        RegA = ra[3:0];
        RegB = rb[3:0];
        Offset = off[11:0];
        branch_condition = cond[4:0];
    endtask

    task automatic do_start(input logic [11:0] base);
        start = 1'b1;
        base_addr = base;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        base_addr = '0;
        s_start = 1'b0;
        s_in_valid = 1'b0;
        s_base_addr = '0;
        set_fields(0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({in_ready, mem_we, full, illegal} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: ready/we/full/illegal=%b, expected 0000",
                     {in_ready, mem_we, full, illegal});
        end
        checks++;
        if (mem_addr !== 12'd0 || mem_data !== 16'd0 || word_count !== 13'd0) begin
            errors++;
            $display("FAIL reset_values: addr=%h data=%h count=%0d, expected 0/0/0",
                     mem_addr, mem_data, word_count);
        end
        $display("reset: ready=%b we=%b addr=%h data=%h count=%0d", in_ready, mem_we,
                 mem_addr, mem_data, word_count);
    endtask

    task automatic test_basic();
        do_start(12'd0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: in_ready=%b, expected 1", in_ready);
        end
        set_fields(4, 1, 2, 3, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 12'd0 || mem_data !== 16'h18d1) begin
            errors++;
            $display("FAIL basic_write: we=%b addr=%h data=%h, expected 1/000/18d1",
                     mem_we, mem_addr, mem_data);
        end
        checks++;
        if (word_count !== 13'd1) begin
            errors++;
            $display("FAIL basic_count: count=%0d, expected 1", word_count);
        end
        $display("basic: id=4 we=%b addr=%h data=%h", mem_we, mem_addr, mem_data);
        step();
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL basic_strobe: we=%b one cycle later, expected 0", mem_we);
        end
    endtask

    task automatic test_back_to_back();
        do_start(12'd0);
        set_fields(73, 0, 0, 0, 'h10, 0);
        in_valid = 1'b1;
        step();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 12'd0 || mem_data !== 16'hd010) begin
            errors++;
            $display("FAIL b2b_first: we=%b addr=%h data=%h, expected 1/000/d010",
                     mem_we, mem_addr, mem_data);
        end
        $display("b2b: id=73 we=%b addr=%h data=%h", mem_we, mem_addr, mem_data);
        set_fields(72, 0, 0, 0, 0, 0);
        step();
        in_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 12'd1 || mem_data !== 16'hc000 || word_count !== 13'd2) begin
            errors++;
            $display("FAIL b2b_second: we=%b addr=%h data=%h count=%0d, expected 1/001/c000/2",
                     mem_we, mem_addr, mem_data, word_count);
        end
        $display("b2b: id=72 we=%b addr=%h data=%h", mem_we, mem_addr, mem_data);
    endtask

    task automatic test_illegal();
        set_fields(99, 1, 1, 1, 1, 1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || illegal !== 1'b1 || word_count !== 13'd2) begin
            errors++;
            $display("FAIL illegal_drop: we=%b illegal=%b count=%0d, expected 0/1/2",
                     mem_we, illegal, word_count);
        end
        set_fields(74, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 12'd2 || mem_data !== 16'he000 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_ptr: we=%b addr=%h data=%h illegal=%b, expected 1/002/e000/1",
                     mem_we, mem_addr, mem_data, illegal);
        end
        do_start(12'd5);
        checks++;
        if (illegal !== 1'b0 || word_count !== 13'd0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: illegal=%b count=%0d we=%b, expected 0/0/0",
                     illegal, word_count, mem_we);
        end
        $display("illegal: after start illegal=%b count=%0d", illegal, word_count);
    endtask

    task automatic test_full();
        s_start = 1'b1;
        s_base_addr = 4'd14;
        step();
        s_start = 1'b0;
        set_fields(72, 0, 0, 0, 0, 0);
        s_in_valid = 1'b1;
        step();
        checks++;
        if (s_mem_we !== 1'b1 || s_mem_addr !== 4'd14 || s_mem_data !== 16'hc000 || s_full !== 1'b0) begin
            errors++;
            $display("FAIL full_first: we=%b addr=%0d data=%h full=%b, expected 1/14/c000/0",
                     s_mem_we, s_mem_addr, s_mem_data, s_full);
        end
        set_fields(74, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (s_mem_we !== 1'b1 || s_mem_addr !== 4'd15 || s_mem_data !== 16'he000 ||
            s_full !== 1'b1 || s_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_last: we=%b addr=%0d data=%h full=%b ready=%b, expected 1/15/e000/1/0",
                     s_mem_we, s_mem_addr, s_mem_data, s_full, s_in_ready);
        end
        set_fields(75, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (s_mem_we !== 1'b0 || s_full !== 1'b1 || s_word_count !== 5'd2 || s_mem_addr !== 4'd15) begin
            errors++;
            $display("FAIL full_hold: we=%b full=%b count=%0d addr=%0d, expected 0/1/2/15",
                     s_mem_we, s_full, s_word_count, s_mem_addr);
        end
        $display("full: full=%b ready=%b count=%0d", s_full, s_in_ready, s_word_count);
        s_start = 1'b1;
        s_base_addr = 4'd3;
        step();
        s_start = 1'b0;
        checks++;
        if (s_mem_we !== 1'b0 || s_full !== 1'b0 || s_in_ready !== 1'b1 || s_word_count !== 5'd0) begin
            errors++;
            $display("FAIL start_priority: we=%b full=%b ready=%b count=%0d, expected 0/0/1/0",
                     s_mem_we, s_full, s_in_ready, s_word_count);
        end
        step();
        s_in_valid = 1'b0;
        checks++;
        if (s_mem_we !== 1'b1 || s_mem_addr !== 4'd3 || s_mem_data !== 16'he800) begin
            errors++;
            $display("FAIL restart_write: we=%b addr=%0d data=%h, expected 1/3/e800",
                     s_mem_we, s_mem_addr, s_mem_data);
        end
    endtask

    task automatic test_reset_mid();
        do_start(12'd0);
        set_fields(100, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        step();
        checks++;
        if (mem_we !== 1'b1 || mem_data !== 16'hffff) begin
            errors++;
            $display("FAIL midreset_pre: we=%b data=%h, expected 1/ffff", mem_we, mem_data);
        end
        set_fields(72, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({mem_we, in_ready, full, illegal} !== 4'b0000 || mem_addr !== 12'd0 ||
            mem_data !== 16'd0 || word_count !== 13'd0) begin
            errors++;
            $display("FAIL midreset_clear: we/ready/full/illegal=%b addr=%h data=%h count=%0d, expected 0000/0/0/0",
                     {mem_we, in_ready, full, illegal}, mem_addr, mem_data, word_count);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: we=%b ready=%b, expected 0/0", mem_we, in_ready);
        end
        $display("midreset: we=%b ready=%b count=%0d", mem_we, in_ready, word_count);
    endtask

    task automatic test_random_ids();
        int ptr;
        int count;
        int cs;
        int base;
        base = $urandom_range(0, 100);
        do_start(base[11:0]);
        ptr = base;
        count = 0;
        cs = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= 79; k++) begin
                int id;
                int rd;
                int ra;
                int rb;
                int off;
                int cond;
                bit legal;
                logic [15:0] exp_word;
                if ($urandom_range(0, 7) == 0) begin
                    id = $urandom_range(79, 127);
                    if (id == 100) id = 0;
                    set_fields(id, 0, 0, 0, 0, 0);
                    in_valid = 1'b1;
                    step();
                    checks++;
                    if (mem_we !== 1'b0 || illegal !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_illegal id=%0d: we=%b illegal=%b, expected 0/1",
                                 id, mem_we, illegal);
                    end
                end
                id = (k == 79) ? 100 : k;
                rd = $urandom_range(0, 15);
                ra = $urandom_range(0, 15);
                rb = $urandom_range(0, 15);
                off = $urandom_range(0, 4095);
                cond = $urandom_range(0, 31);
                exp_word = ref_word(id, rd, ra, rb, off, cond, legal);
                set_fields(id, rd, ra, rb, off, cond);
                in_valid = 1'b1;
                step();
                if (legal) begin
                    count++;
                    cs = (cs + exp_word) % 65536;
                end
                checks++;
                if (mem_we !== legal || (legal && (mem_addr !== ptr[11:0] || mem_data !== exp_word))) begin
                    errors++;
                    $display("FAIL rand_write id=%0d: we=%b addr=%h data=%h, expected %b/%h/%h",
                             id, mem_we, mem_addr, mem_data, legal, ptr[11:0], exp_word);
                end
                if (legal) ptr++;
                checks++;
                if (word_count !== count[12:0]) begin
                    errors++;
                    $display("FAIL rand_count id=%0d: count=%0d, expected %0d", id, word_count, count);
                end
`ifdef ENCODER_CHECKSUM_EN
                checks++;
                if (checksum !== cs[15:0]) begin
                    errors++;
                    $display("FAIL rand_checksum id=%0d: checksum=%h, expected %h", id, checksum, cs[15:0]);
                end
`endif
                $display("rand: id=%0d rd=%0d ra=%0d rb=%0d off=%h cond=%0d -> we=%b addr=%h data=%h",
                         id, rd, ra, rb, off, cond, mem_we, mem_addr, mem_data);
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    step();
                    checks++;
                    if (mem_we !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_gap: we=%b, expected 0", mem_we);
                    end
                end
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_full();
        test_reset_mid();
        test_random_ids();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
